// File: rtl/imm_encoder.sv
// imm_encoder: packs a 32-bit immediate into the immediate fields of a RISC-V
// instruction word (inverse of the decoder's immediate generator), flags range,
// alignment and type errors, and presents the result through a 2-stage
// valid/ready pipeline with saturating handshake statistics.
//
// Ports:
//   clk        - clock, all state on posedge
//   rst_n      - synchronous active-low reset
//   in_valid   - request valid;       in_ready - request accepted when both high
//   ImmSel     - I=001 B=010 J=011 S=100 U=101, others invalid
//   imm        - immediate value (byte offset for B/J)
//   base_inst  - instruction template; its immediate bits are replaced
//   out_valid  - result valid;        out_ready - downstream accepts when both high
//   inst_out   - encoded instruction
//   err_out    - {err_type, err_align, err_range}
//   enc_count  - saturating count of output handshakes
//   err_count  - saturating count of output handshakes with err_out != 0
module imm_encoder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ImmSel,
  input  logic [31:0]      imm,
  input  logic [31:0]      base_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      inst_out,
  output logic [2:0]       err_out,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [2:0] SelI = 3'b001;
  localparam logic [2:0] SelB = 3'b010;
  localparam logic [2:0] SelJ = 3'b011;
  localparam logic [2:0] SelS = 3'b100;
  localparam logic [2:0] SelU = 3'b101;

  // Combinational encoder
  logic [31:0] enc_inst;
  logic        enc_type, enc_align, enc_range;

  always_comb begin
    enc_inst  = base_inst;
    enc_type  = 1'b0;
    enc_align = 1'b0;
    enc_range = 1'b0;
    case (ImmSel)
      SelI: begin
        enc_inst  = {imm[11:0], base_inst[19:0]};
        // Sign-extension check: all upper bits must match the field's sign bit.
        enc_range = !((&imm[31:11]) || !(|imm[31:11]));
      end
      SelS: begin
        enc_inst  = {imm[11:5], base_inst[24:12], imm[4:0], base_inst[6:0]};
        enc_range = !((&imm[31:11]) || !(|imm[31:11]));
      end
      SelB: begin
        enc_inst  = {imm[12], imm[10:5], base_inst[24:12], imm[4:1], imm[11], base_inst[6:0]};
        enc_range = !((&imm[31:12]) || !(|imm[31:12]));
        enc_align = imm[0];
      end
      SelJ: begin
        enc_inst  = {imm[20], imm[10:1], imm[11], imm[19:12], base_inst[11:0]};
        enc_range = !((&imm[31:20]) || !(|imm[31:20]));
        enc_align = imm[0];
      end
      SelU: begin
        enc_inst  = {imm[31:12], base_inst[11:0]};
        enc_range = |imm[11:0];
      end
      default: begin
        enc_inst = base_inst;
        enc_type = 1'b1;
      end
    endcase
  end

  // Pipeline
  logic              s1_valid_q, s1_valid_d;
  logic [31:0]       s1_inst_q, s1_inst_d;
  logic [2:0]        s1_err_q, s1_err_d;
  logic              s2_valid_q, s2_valid_d;
  logic [31:0]       s2_inst_q, s2_inst_d;
  logic [2:0]        s2_err_q, s2_err_d;
  logic [CNT_W-1:0]  enc_count_q, enc_count_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic              adv1, adv2, out_hs;

  assign adv2     = !s2_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;
  assign out_hs   = s2_valid_q && out_ready;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_inst_d   = s1_inst_q;
    s1_err_d    = s1_err_q;
    s2_valid_d  = s2_valid_q;
    s2_inst_d   = s2_inst_q;
    s2_err_d    = s2_err_q;
    enc_count_d = enc_count_q;
    err_count_d = err_count_q;

    if (adv1) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_inst_d = enc_inst;
        s1_err_d  = {enc_type, enc_align, enc_range};
      end
    end

    // Output data only changes when a new result moves in, so it stays stable under stall.
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_inst_d = s1_inst_q;
        s2_err_d  = s1_err_q;
      end
    end

    if (out_hs) begin
      if (enc_count_q != '1) enc_count_d = enc_count_q + CNT_W'(1);
      if ((s2_err_q != 3'b000) && (err_count_q != '1)) err_count_d = err_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_inst_q   <= '0;
      s1_err_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_inst_q   <= '0;
      s2_err_q    <= '0;
      enc_count_q <= '0;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_inst_q   <= s1_inst_d;
      s1_err_q    <= s1_err_d;
      s2_valid_q  <= s2_valid_d;
      s2_inst_q   <= s2_inst_d;
      s2_err_q    <= s2_err_d;
      enc_count_q <= enc_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign inst_out  = s2_inst_q;
  assign err_out   = s2_err_q;
  assign enc_count = enc_count_q;
  assign err_count = err_count_q;

endmodule
